// File: rtl/axis_arb_pkg.sv
// ============================================================================
//  axis_arb_pkg : stream types, FSM state and pointer-width helper shared by
//                 the cross-router output arbiter.   Revision 1.0
// ============================================================================
`default_nettype none

package axis_arb_pkg;

    localparam int DATA_WIDTH = 32;
`ifdef TID_PRESENT
    localparam int ID_WIDTH   = 4;
`endif
`ifdef TDEST_PRESENT
    localparam int DEST_WIDTH = 4;
`endif
`ifdef TUSER_PRESENT
    localparam int USER_WIDTH = 4;
`endif

    // Everything that travels with a beat; sideband fields exist only when enabled.
    typedef struct packed {
`ifdef TID_PRESENT
        logic [ID_WIDTH-1:0]   TID;
`endif
`ifdef TDEST_PRESENT
        logic [DEST_WIDTH-1:0] TDEST;
`endif
`ifdef TUSER_PRESENT
        logic [USER_WIDTH-1:0] TUSER;
`endif
        logic                  TLAST;
        logic [DATA_WIDTH-1:0] TDATA;
    } axis_data_t;

    typedef struct packed {
        logic       TVALID;
        axis_data_t data;
    } axis_mosi_t;

    typedef struct packed {
        logic TREADY;
    } axis_miso_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  rr_pick : combinational round-robin pick - first request at or after
//            prio_ptr, wrapping modulo PORT_COUNT.   Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import axis_arb_pkg::*;
#(
    parameter  int PORT_COUNT = 4,
    localparam int PTR_W      = ptr_w(PORT_COUNT)
) (
    input  logic [PORT_COUNT-1:0] req_i,
    input  logic [PTR_W-1:0]      prio_ptr_i,
    output logic [PTR_W-1:0]      grant_idx_o,
    output logic                  any_req_o
);

    localparam logic [PTR_W:0] c_PORTS = (PTR_W+1)'(PORT_COUNT);

    logic [2*PORT_COUNT-1:0] w_dbl;
    logic [PORT_COUNT-1:0]   w_rot;
    logic [PTR_W-1:0]        w_off;
    logic [PTR_W:0]          w_sum;

    // Shifting the doubled vector puts prio_ptr at bit 0, so a plain
    // lowest-index search yields the round-robin winner as an offset.
    assign w_dbl = {req_i, req_i};

    always_comb begin
        w_rot = PORT_COUNT'(w_dbl >> prio_ptr_i);
    end

    always_comb begin
        w_off = '0;
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PTR_W'(i);
            end
        end
    end

    assign w_sum       = {1'b0, prio_ptr_i} + {1'b0, w_off};
    assign grant_idx_o = (w_sum >= c_PORTS) ? PTR_W'(w_sum - c_PORTS) : w_sum[PTR_W-1:0];
    assign any_req_o   = |req_i;

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
//  axis_rr_arbiter : packet-level round-robin merge of PORT_COUNT AXI-Stream
//                    inputs onto one registered output.   Revision 1.0
// ============================================================================
`default_nettype none

module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int PORT_COUNT = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  axis_mosi_t in_mosi_i [PORT_COUNT],
    output axis_miso_t in_miso_o [PORT_COUNT],
    output axis_mosi_t out_mosi_o,
    input  axis_miso_t out_miso_i
);

    localparam int              PTR_W       = ptr_w(PORT_COUNT);
    localparam logic [PTR_W-1:0] c_LAST_PORT = PTR_W'(PORT_COUNT - 1);

    arb_state_t             r_state;
    logic [PTR_W-1:0]       r_prio_ptr;
    logic [PTR_W-1:0]       r_grant_idx;
    axis_mosi_t             r_out;

    logic [PORT_COUNT-1:0]  w_req;
    logic [PTR_W-1:0]       w_pick;
    logic                   w_any_req;
    logic                   w_out_free;
    logic                   w_accept;
    axis_mosi_t             w_gnt_beat;

    // Only the locked port ever sees TREADY; it follows downstream ready
    // combinationally so a full output register can still refill each cycle.
    for (genvar k = 0; k < PORT_COUNT; k++) begin : g_port
        assign w_req[k]           = in_mosi_i[k].TVALID;
        assign in_miso_o[k].TREADY = (r_state == ARB_LOCKED) &&
                                     (r_grant_idx == PTR_W'(k)) && w_out_free;
    end

    rr_pick #(
        .PORT_COUNT (PORT_COUNT)
    ) u_pick (
        .req_i       (w_req),
        .prio_ptr_i  (r_prio_ptr),
        .grant_idx_o (w_pick),
        .any_req_o   (w_any_req)
    );

    assign w_gnt_beat = in_mosi_i[r_grant_idx];
    assign w_out_free = !r_out.TVALID || out_miso_i.TREADY;
    assign w_accept   = (r_state == ARB_LOCKED) && w_gnt_beat.TVALID && w_out_free;
    assign out_mosi_o = r_out;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ARB_IDLE;
            r_prio_ptr  <= '0;
            r_grant_idx <= '0;
            r_out       <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_grant_idx <= w_pick;
                        r_state     <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    // Source bubbles and other requesters never break the lock.
                    if (w_accept && w_gnt_beat.data.TLAST) begin
                        r_state    <= ARB_IDLE;
                        r_prio_ptr <= (r_grant_idx == c_LAST_PORT) ? '0 : r_grant_idx + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase

            if (w_accept) begin
                r_out.TVALID <= 1'b1;
                r_out.data   <= w_gnt_beat.data;
            end else if (r_out.TVALID && out_miso_i.TREADY) begin
                r_out.TVALID <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ============================================================================
//  tb_axis_rr_arbiter : directed self-checking bench for axis_rr_arbiter.
//                       Revision 1.0
// ============================================================================
`default_nettype none

module tb_axis_rr_arbiter;
    import axis_arb_pkg::*;

    localparam int NP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    axis_mosi_t in_mosi [NP];
    axis_miso_t in_miso [NP];
    axis_mosi_t out_mosi;
    axis_miso_t out_miso;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-port beat FIFOs: {TLAST, TDATA}, TDATA = {port, sequence}
    logic [32:0] src_mem  [NP][0:63];
    int          src_head [NP];
    int          src_tail [NP];
    bit          src_en   [NP];
    bit          fire     [NP];

    logic [32:0] cap_q[$];
    int          cap_cyc[$];

    always #5 clk = ~clk;

    axis_rr_arbiter #(.PORT_COUNT(NP)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_mosi_i  (in_mosi),
        .in_miso_o  (in_miso),
        .out_mosi_o (out_mosi),
        .out_miso_i (out_miso)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < NP; k++)
            fire[k] = rst_n && in_mosi[k].TVALID && in_miso[k].TREADY;
        if (rst_n && out_mosi.TVALID && out_miso.TREADY) begin
            cap_q.push_back({out_mosi.data.TLAST, out_mosi.data.TDATA});
            cap_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NP; k++) begin
            if (fire[k] && src_head[k] != src_tail[k]) src_head[k]++;
            fire[k] = 1'b0;
            in_mosi[k] = '0;
            in_mosi[k].TVALID = rst_n && src_en[k] && (src_head[k] != src_tail[k]);
            if (src_head[k] != src_tail[k]) begin
                in_mosi[k].data.TLAST = src_mem[k][src_head[k]][32];
                in_mosi[k].data.TDATA = src_mem[k][src_head[k]][31:0];
            end
        end
    end

    function automatic logic [32:0] beat(input int p, input int s, input bit last);
        return {last, p[7:0], s[23:0]};
    endfunction

    task automatic push_pkt(input int p, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            src_mem[p][src_tail[p]] = beat(p, base + i, i == n - 1);
            src_tail[p]++;
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < NP; k++) begin
            src_head[k] = 0;
            src_tail[k] = 0;
            src_en[k]   = 1'b1;
            fire[k]     = 1'b0;
        end
        cap_q.delete();
        cap_cyc.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_caps(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cap_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        clear_all();
    endtask

    task automatic test_reset();
        bit          seen;
        logic [32:0] exp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_mosi.TVALID !== 1'b0 || out_mosi.data !== '0) begin
            errors++;
            $display("FAIL reset_out: got valid=%0b data=%h, expected valid=0 data=0", out_mosi.TVALID, out_mosi.data);
        end
        for (int k = 0; k < NP; k++) begin
            checks++;
            if (in_miso[k].TREADY !== 1'b0) begin
                errors++;
                $display("FAIL reset_tready[%0d]: got %0b expected 0", k, in_miso[k].TREADY);
            end
        end
        rst_n = 1'b1;
        push_pkt(1, 0, 4);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_mosi.TVALID) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_prepkt: no output beat within 10 cycles, expected one");
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_mosi.TVALID !== 1'b0 || out_mosi.data !== '0) begin
            errors++;
            $display("FAIL reset_async_out: got valid=%0b data=%h, expected valid=0 data=0", out_mosi.TVALID, out_mosi.data);
        end
        checks++;
        if (in_miso[1].TREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_tready: got %0b expected 0", in_miso[1].TREADY);
        end
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_pkt(2, 0, 1);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (in_mosi[2].TVALID) seen = 1'b1;
        end
        checks++;
        if (!seen || in_miso[2].TREADY !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle0: got seen=%0b tready=%0b, expected seen=1 tready=0", seen, in_miso[2].TREADY);
        end
        @(negedge clk);
        checks++;
        if (in_miso[2].TREADY !== 1'b1 || out_mosi.TVALID !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle1: got tready=%0b out_valid=%0b, expected 1 and 0", in_miso[2].TREADY, out_mosi.TVALID);
        end
        @(negedge clk);
        exp = beat(2, 0, 1'b1);
        checks++;
        if (out_mosi.TVALID !== 1'b1 || {out_mosi.data.TLAST, out_mosi.data.TDATA} !== exp) begin
            errors++;
            $display("FAIL lat_cycle2: got valid=%0b beat=%h, expected valid=1 beat=%h",
                     out_mosi.TVALID, {out_mosi.data.TLAST, out_mosi.data.TDATA}, exp);
        end
        settle();
    endtask

    task automatic test_fairness();
        bit          ok;
        bit          miss;
        logic [32:0] exp;
        apply_reset();
        for (int p = 0; p < NP; p++) begin
            push_pkt(p, 0, 1);
            push_pkt(p, 1, 1);
        end
        wait_caps(8, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fair_count: got %0d beats, expected 8", cap_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            exp  = beat(i % 4, i / 4, 1'b1);
            miss = (i >= cap_q.size());
            checks++;
            if (miss || cap_q[i] !== exp) begin
                errors++;
                $display("FAIL fair_order[%0d]: got %h (missing=%0b), expected %h", i, miss ? 33'h0 : cap_q[i], miss, exp);
            end
        end
        for (int i = 1; i < cap_cyc.size() && i < 8; i++) begin
            checks++;
            if (cap_cyc[i] - cap_cyc[i-1] != 2) begin
                errors++;
                $display("FAIL fair_gap[%0d]: got %0d cycles between beats, expected 2", i, cap_cyc[i] - cap_cyc[i-1]);
            end
        end
        settle();
    endtask

    task automatic test_no_interleave();
        bit          ok;
        bit          seen;
        bit          miss;
        logic [32:0] exp;
        push_pkt(1, 0, 5);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (in_miso[1].TREADY) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL nointl_grant: port 1 not granted within 10 cycles, expected grant");
        end
        push_pkt(0, 0, 1);
        @(negedge clk);
        push_pkt(2, 0, 1);
        @(negedge clk);
        src_en[0] = 1'b0;
        wait_caps(6, 40, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (cap_q.size() != 6) begin
            errors++;
            $display("FAIL nointl_count: got %0d beats, expected 6", cap_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            exp  = (i < 5) ? beat(1, i, i == 4) : beat(2, 0, 1'b1);
            miss = (i >= cap_q.size());
            checks++;
            if (miss || cap_q[i] !== exp) begin
                errors++;
                $display("FAIL nointl_order[%0d]: got %h (missing=%0b), expected %h", i, miss ? 33'h0 : cap_q[i], miss, exp);
            end
        end
        settle();
    endtask

    task automatic test_backpressure();
        bit          ok;
        bit          miss;
        bit          pv;
        bit          pr;
        logic [31:0] pd;
        logic [3:0]  pat;
        logic [32:0] exp;
        pat = 4'b1001;
        pv  = 1'b0;
        pr  = 1'b1;
        pd  = '0;
        push_pkt(0, 0, 8);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            out_miso.TREADY = pat[i % 4];
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if (out_mosi.TVALID !== 1'b1 || out_mosi.data.TDATA !== pd) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%0b data=%h, expected valid=1 data=%h", out_mosi.TVALID, out_mosi.data.TDATA, pd);
                end
            end
            if (out_mosi.TVALID && !out_miso.TREADY) begin
                checks++;
                if (in_miso[0].TREADY !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_tready: got %0b while output stalled, expected 0", in_miso[0].TREADY);
                end
            end
            pv = out_mosi.TVALID;
            pr = out_miso.TREADY;
            pd = out_mosi.data.TDATA;
        end
        out_miso.TREADY = 1'b1;
        wait_caps(8, 20, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (cap_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d beats, expected 8", cap_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            exp  = beat(0, i, i == 7);
            miss = (i >= cap_q.size());
            checks++;
            if (miss || cap_q[i] !== exp) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h (missing=%0b), expected %h", i, miss ? 33'h0 : cap_q[i], miss, exp);
            end
        end
        settle();
    endtask

    task automatic test_bubble();
        bit          ok;
        bit          seen;
        bit          miss;
        logic [32:0] exp;
        push_pkt(1, 0, 6);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (in_miso[1].TREADY) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bubble_grant: port 1 not granted within 10 cycles, expected grant");
        end
        repeat (2) @(negedge clk);
        src_en[1] = 1'b0;
        push_pkt(3, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_miso[3].TREADY !== 1'b0) begin
                errors++;
                $display("FAIL bubble_hold[%0d]: port 3 tready got %0b, expected 0", i, in_miso[3].TREADY);
            end
        end
        src_en[1] = 1'b1;
        wait_caps(7, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bubble_count: got %0d beats, expected 7", cap_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            exp  = (i < 6) ? beat(1, i, i == 5) : beat(3, 0, 1'b1);
            miss = (i >= cap_q.size());
            checks++;
            if (miss || cap_q[i] !== exp) begin
                errors++;
                $display("FAIL bubble_order[%0d]: got %h (missing=%0b), expected %h", i, miss ? 33'h0 : cap_q[i], miss, exp);
            end
        end
        settle();
    endtask

    task automatic test_wrap();
        bit          ok;
        bit          miss;
        logic [32:0] exp;
        push_pkt(2, 0, 1);
        wait_caps(1, 20, ok);
        exp  = beat(2, 0, 1'b1);
        miss = (cap_q.size() == 0);
        checks++;
        if (miss || cap_q[0] !== exp) begin
            errors++;
            $display("FAIL wrap_setup: got %h (missing=%0b), expected %h", miss ? 33'h0 : cap_q[0], miss, exp);
        end
        settle();
        push_pkt(0, 0, 1);
        push_pkt(3, 0, 1);
        wait_caps(2, 20, ok);
        for (int i = 0; i < 2; i++) begin
            exp  = (i == 0) ? beat(3, 0, 1'b1) : beat(0, 0, 1'b1);
            miss = (i >= cap_q.size());
            checks++;
            if (miss || cap_q[i] !== exp) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %h (missing=%0b), expected %h", i, miss ? 33'h0 : cap_q[i], miss, exp);
            end
        end
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        out_miso.TREADY = 1'b1;
        for (int k = 0; k < NP; k++) in_mosi[k] = '0;
        clear_all();
        test_reset();
        test_fairness();
        test_no_interleave();
        test_backpressure();
        test_bubble();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
